mem_port_arbiter: RTL and testbench

//  Shares one memory port between instruction fetch (IF) and load/store (MEM) requesters.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_arb_prio_sel.sv | 37 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: FSM state codes, owner tags
// and the saturating counter helper used by the starvation guard.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_OWNER_IF  = 1'b0,
      ARB_OWNER_MEM = 1'b1
   } arb_owner_e;

   localparam int STARVE_CNT_W = 4;

   function automatic logic [STARVE_CNT_W-1:0] sat_inc(
      input logic [STARVE_CNT_W-1:0] cnt,
      input logic [STARVE_CNT_W-1:0] limit
   );
      return (cnt == limit) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// Grant select between IF and MEM requesters: MEM has priority until it has won
// STARVE_LIMIT grants in a row while IF was waiting, then IF is forced.
module arb_prio_sel
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic idle,
   input  logic if_req_valid,
   input  logic mem_req_valid,
   output logic grant_if,
   output logic grant_mem
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] starve_cnt;
   logic                    starve_hit;

   assign starve_hit = if_req_valid && (starve_cnt == LIMIT);
   assign grant_mem  = idle && mem_req_valid && !starve_hit;
   assign grant_if   = idle && if_req_valid && !grant_mem;

   // The count only moves in IDLE; busy cycles leave it untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (grant_if || (idle && !if_req_valid)) begin
         starve_cnt <= '0;
      end else if (grant_mem) begin
         starve_cnt <= sat_inc(starve_cnt, LIMIT);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and MEM with one outstanding transaction.
// Define MEM_PORT_ARB_PERF_EN to build the per-requester grant counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_resp_valid,
   output logic [DATA_W-1:0]   if_resp_data,
   input  logic                mem_req_valid,
   output logic                mem_req_ready,
   input  logic                mem_req_wen,
   input  logic [ADDR_W-1:0]   mem_req_addr,
   input  logic [DATA_W-1:0]   mem_req_wdata,
   input  logic [DATA_W/8-1:0] mem_req_wstrb,
   output logic                mem_resp_valid,
   output logic [DATA_W-1:0]   mem_resp_data,
   output logic                bus_req_valid,
   input  logic                bus_req_ready,
   output logic                bus_req_wen,
   output logic [ADDR_W-1:0]   bus_req_addr,
   output logic [DATA_W-1:0]   bus_req_wdata,
   output logic [DATA_W/8-1:0] bus_req_wstrb,
   input  logic                bus_resp_valid,
   input  logic [DATA_W-1:0]   bus_resp_data,
   output logic [31:0]         perf_if_cnt,
   output logic [31:0]         perf_mem_cnt
);

   // Handshake: a request transfers in the cycle its valid and ready are both
   // high; ready is only ever high in IDLE, so a dropped valid simply never transfers.
   arb_state_e state, state_nxt;
   arb_owner_e owner;
   logic       grant_if, grant_mem;
   logic       resp_done;

   arb_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio_sel (
      .clock        (clock),
      .reset        (reset),
      .idle         (state == ARB_IDLE),
      .if_req_valid (if_req_valid),
      .mem_req_valid(mem_req_valid),
      .grant_if     (grant_if),
      .grant_mem    (grant_mem)
   );

   assign if_req_ready  = grant_if;
   assign mem_req_ready = grant_mem;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus_req_valid = 1'b0;
      resp_done     = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (grant_if || grant_mem) state_nxt = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            bus_req_valid = 1'b1;
            if (bus_req_ready) state_nxt = ARB_WAIT;
         end
         ARB_WAIT: begin
            resp_done = bus_resp_valid;
            if (bus_resp_valid) state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Responses are steered only to the recorded owner; stores return zero data.
   assign if_resp_valid  = resp_done && (owner == ARB_OWNER_IF);
   assign mem_resp_valid = resp_done && (owner == ARB_OWNER_MEM);
   assign if_resp_data   = if_resp_valid ? bus_resp_data : '0;
   assign mem_resp_data  = (mem_resp_valid && !bus_req_wen) ? bus_resp_data : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         owner         <= ARB_OWNER_IF;
         bus_req_wen   <= 1'b0;
         bus_req_addr  <= '0;
         bus_req_wdata <= '0;
         bus_req_wstrb <= '0;
      end else if (grant_mem) begin
         owner         <= ARB_OWNER_MEM;
         bus_req_wen   <= mem_req_wen;
         bus_req_addr  <= mem_req_addr;
         bus_req_wdata <= mem_req_wdata;
         bus_req_wstrb <= mem_req_wstrb;
      end else if (grant_if) begin
         owner         <= ARB_OWNER_IF;
         bus_req_wen   <= 1'b0;
         bus_req_addr  <= if_req_addr;
         bus_req_wdata <= '0;
         bus_req_wstrb <= '0;
      end
   end

`ifdef MEM_PORT_ARB_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_if_cnt  <= '0;
         perf_mem_cnt <= '0;
      end else begin
         if (grant_if)  perf_if_cnt  <= perf_if_cnt + 32'd1;
         if (grant_mem) perf_mem_cnt <= perf_mem_cnt + 32'd1;
      end
   end
`else
   assign perf_if_cnt  = '0;
   assign perf_mem_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

   localparam int AW    = 64;
   localparam int DW    = 64;
   localparam int SW    = DW / 8;
   localparam int LIMIT = 4;
   localparam int FW    = 1 + AW + DW + SW;

   logic          clock = 1'b0;
   logic          reset;
   logic          if_req_valid, if_req_ready;
   logic [AW-1:0] if_req_addr;
   logic          if_resp_valid;
   logic [DW-1:0] if_resp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_wen;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_wdata;
   logic [SW-1:0] mem_req_wstrb;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;
   logic          bus_req_valid, bus_req_ready, bus_req_wen;
   logic [AW-1:0] bus_req_addr;
   logic [DW-1:0] bus_req_wdata;
   logic [SW-1:0] bus_req_wstrb;
   logic          bus_resp_valid;
   logic [DW-1:0] bus_resp_data;
   logic [31:0]   perf_if_cnt, perf_mem_cnt;

   int errors = 0;
   int checks = 0;
   int streak = 0;
   logic [FW-1:0] exp_q[$];

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(bus_req_wen),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
      .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
      .perf_if_cnt(perf_if_cnt), .perf_mem_cnt(perf_mem_cnt)
   );

   // Clock and reset
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic idle_inputs;
      if_req_valid   = 1'b0;
      if_req_addr    = '0;
      mem_req_valid  = 1'b0;
      mem_req_wen    = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
      mem_req_wstrb  = '0;
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_resp_data  = '0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset  = 1'b0;
      streak = 0;
   endtask

   // Reference model: MEM wins unless IF is waiting and MEM already took
   // LIMIT grants in a row; an IDLE cycle without an IF request clears the run.
   function automatic bit model_mem_wins(input bit ifv, input bit memv);
      return memv && !(ifv && streak == LIMIT);
   endfunction

   task automatic model_idle_cycle(input bit ifv, input bit memv);
      if (!ifv) streak = 0;
      else if (model_mem_wins(ifv, memv)) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
      else streak = 0;
   endtask

   // Driver: one complete transaction on a single requester, bus answering promptly.
   task automatic simple_txn(input bit is_mem, input logic [AW-1:0] addr);
      if_req_valid  = !is_mem;
      mem_req_valid = is_mem;
      if_req_addr   = addr;
      mem_req_addr  = addr;
      tick();
      if_req_valid  = 1'b0;
      mem_req_valid = 1'b0;
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b1;
      bus_resp_data  = {$urandom, $urandom};
      tick();
      bus_resp_valid = 1'b0;
      model_idle_cycle(1'b0, 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      tick();
      settle();
      checks++;
      if ({if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid, bus_req_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_valids got=%b want=00000",
                  {if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid, bus_req_valid});
      end
      checks++;
      if ({bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb} !== {FW{1'b0}}) begin
         errors++;
         $display("FAIL reset_bus_fields got addr=%h wdata=%h wstrb=%h wen=%b want all 0",
                  bus_req_addr, bus_req_wdata, bus_req_wstrb, bus_req_wen);
      end
      checks++;
      if ({perf_if_cnt, perf_mem_cnt} !== 64'd0) begin
         errors++;
         $display("FAIL reset_perf got if=%0d mem=%0d want 0/0", perf_if_cnt, perf_mem_cnt);
      end
      reset  = 1'b0;
      streak = 0;
      tick();
   endtask

   task automatic test_if_fetch;
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0000;
      settle();
      checks++;
      if ({if_req_ready, mem_req_ready} !== 2'b10) begin
         errors++;
         $display("FAIL if_fetch_ready got=%b want=10", {if_req_ready, mem_req_ready});
      end
      tick();
      if_req_valid  = 1'b0;
      if_req_addr   = '1;
      bus_req_ready = 1'b1;
      settle();
      checks++;
      if ({bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wstrb} !== {1'b1, 1'b0, 64'h8000_0000, 8'h00}) begin
         errors++;
         $display("FAIL if_fetch_issue got valid=%b wen=%b addr=%h wstrb=%h want 1 0 80000000 00",
                  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wstrb);
      end
      tick();
      bus_req_ready = 1'b0;
      settle();
      checks++;
      if ({if_resp_valid, mem_resp_valid, bus_req_valid} !== 3'b000) begin
         errors++;
         $display("FAIL if_fetch_wait_quiet got=%b want=000", {if_resp_valid, mem_resp_valid, bus_req_valid});
      end
      tick();
      bus_resp_valid = 1'b1;
      bus_resp_data  = 64'h13;
      settle();
      checks++;
      if ({if_resp_valid, mem_resp_valid, if_resp_data} !== {2'b10, 64'h13}) begin
         errors++;
         $display("FAIL if_fetch_resp got if_v=%b mem_v=%b data=%h want 1 0 13",
                  if_resp_valid, mem_resp_valid, if_resp_data);
      end
      tick();
      bus_resp_valid = 1'b0;
      settle();
      checks++;
      if (if_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL if_fetch_pulse_width got=%b want=0", if_resp_valid);
      end
      model_idle_cycle(1'b0, 1'b0);
      tick();
   endtask

   task automatic test_starvation;
      logic [5:0] order;
      bit want_mem;
      if_req_valid  = 1'b1;
      mem_req_valid = 1'b1;
      mem_req_wen   = 1'b0;
      if_req_addr   = 64'h1000;
      mem_req_addr  = 64'h2000;
      for (int g = 0; g < 6; g++) begin
         settle();
         want_mem = model_mem_wins(1'b1, 1'b1);
         order[g] = mem_req_ready;
         checks++;
         if ({if_req_ready, mem_req_ready} !== {!want_mem, want_mem}) begin
            errors++;
            $display("FAIL starve_grant_%0d got if=%b mem=%b want if=%b mem=%b",
                     g, if_req_ready, mem_req_ready, !want_mem, want_mem);
         end
         model_idle_cycle(1'b1, 1'b1);
         tick();
         bus_req_ready = 1'b1;
         settle();
         checks++;
         if ({if_req_ready, mem_req_ready, bus_req_addr} !== {2'b00, want_mem ? 64'h2000 : 64'h1000}) begin
            errors++;
            $display("FAIL starve_issue_%0d got readies=%b addr=%h want 00 %h", g,
                     {if_req_ready, mem_req_ready}, bus_req_addr, want_mem ? 64'h2000 : 64'h1000);
         end
         tick();
         bus_req_ready  = 1'b0;
         bus_resp_valid = 1'b1;
         bus_resp_data  = 64'(g + 100);
         settle();
         checks++;
         if ({if_resp_valid, mem_resp_valid} !== {!want_mem, want_mem}) begin
            errors++;
            $display("FAIL starve_resp_%0d got if=%b mem=%b want if=%b mem=%b",
                     g, if_resp_valid, mem_resp_valid, !want_mem, want_mem);
         end
         tick();
         bus_resp_valid = 1'b0;
      end
      checks++;
      if (order !== 6'b101111) begin
         errors++;
         $display("FAIL starve_order got=%b want=101111 (M,M,M,M,I,M from bit 0)", order);
      end
      idle_inputs();
      model_idle_cycle(1'b0, 1'b0);
      tick();
   endtask

   task automatic test_store_stall;
      logic [DW-1:0] wd;
      wd = {$urandom, $urandom};
      mem_req_valid = 1'b1;
      mem_req_wen   = 1'b1;
      mem_req_addr  = 64'h40;
      mem_req_wdata = wd;
      mem_req_wstrb = 8'h0F;
      settle();
      checks++;
      if (mem_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL store_ready got=%b want=1", mem_req_ready);
      end
      tick();
      mem_req_valid = 1'b0;
      mem_req_addr  = '1;
      mem_req_wdata = ~wd;
      mem_req_wstrb = 8'hF0;
      for (int c = 0; c < 3; c++) begin
         settle();
         checks++;
         if ({bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb}
             !== {2'b11, 64'h40, wd, 8'h0F}) begin
            errors++;
            $display("FAIL store_stall_%0d got v=%b wen=%b addr=%h wd=%h st=%h want 1 1 40 %h 0f",
                     c, bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb, wd);
         end
         tick();
      end
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b1;
      bus_resp_data  = 64'hDEAD_BEEF;
      settle();
      checks++;
      if ({mem_resp_valid, if_resp_valid, mem_resp_data} !== {2'b10, 64'd0}) begin
         errors++;
         $display("FAIL store_ack got mem_v=%b if_v=%b data=%h want 1 0 0",
                  mem_resp_valid, if_resp_valid, mem_resp_data);
      end
      tick();
      idle_inputs();
      model_idle_cycle(1'b0, 1'b0);
      tick();
   endtask

   task automatic test_spurious_resp;
      bus_resp_valid = 1'b1;
      bus_resp_data  = 64'h77;
      for (int c = 0; c < 2; c++) begin
         settle();
         checks++;
         if ({if_resp_valid, mem_resp_valid, bus_req_valid} !== 3'b000) begin
            errors++;
            $display("FAIL spurious_idle_%0d got=%b want=000", c, {if_resp_valid, mem_resp_valid, bus_req_valid});
         end
         model_idle_cycle(1'b0, 1'b0);
         tick();
      end
      bus_resp_valid = 1'b0;
      mem_req_valid  = 1'b1;
      mem_req_addr   = 64'h88;
      tick();
      mem_req_valid = 1'b0;
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b1;
      bus_resp_data  = 64'hCAFE;
      settle();
      checks++;
      if ({mem_resp_valid, if_resp_valid, mem_resp_data} !== {2'b10, 64'hCAFE}) begin
         errors++;
         $display("FAIL spurious_followup got mem_v=%b if_v=%b data=%h want 1 0 cafe",
                  mem_resp_valid, if_resp_valid, mem_resp_data);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_in_wait;
      if_req_valid = 1'b1;
      if_req_addr  = 64'h500;
      tick();
      if_req_valid  = 1'b0;
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      reset         = 1'b1;
      tick();
      reset          = 1'b0;
      streak         = 0;
      bus_resp_valid = 1'b1;
      bus_resp_data  = 64'h55;
      settle();
      checks++;
      if ({if_resp_valid, mem_resp_valid, bus_req_valid, if_req_ready, mem_req_ready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_wait_pulse got=%b want=00000",
                  {if_resp_valid, mem_resp_valid, bus_req_valid, if_req_ready, mem_req_ready});
      end
      checks++;
      if ({bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb, perf_if_cnt, perf_mem_cnt}
          !== {(FW + 64){1'b0}}) begin
         errors++;
         $display("FAIL reset_wait_fields got addr=%h perf=%0d/%0d want 0 and 0/0",
                  bus_req_addr, perf_if_cnt, perf_mem_cnt);
      end
      tick();
      bus_resp_valid = 1'b0;
      tick();
   endtask

   task automatic test_random;
      bit ifv, memv, want_mem, m_wen;
      logic [AW-1:0] i_addr, m_addr;
      logic [DW-1:0] m_wd, rd;
      logic [SW-1:0] m_st;
      logic [FW-1:0] exp_f;
      int d;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle_inputs();
            model_idle_cycle(1'b0, 1'b0);
            tick();
         end
         d      = $urandom_range(1, 3);
         ifv    = d[0];
         memv   = d[1];
         i_addr = {$urandom, $urandom};
         m_addr = {$urandom, $urandom};
         m_wd   = {$urandom, $urandom};
         m_st   = 8'($urandom);
         m_wen  = 1'($urandom);
         if_req_valid  = ifv;
         if_req_addr   = i_addr;
         mem_req_valid = memv;
         mem_req_addr  = m_addr;
         mem_req_wdata = m_wd;
         mem_req_wstrb = m_st;
         mem_req_wen   = m_wen;
         settle();
         want_mem = model_mem_wins(ifv, memv);
         checks++;
         if ({if_req_ready, mem_req_ready} !== {!want_mem, want_mem}) begin
            errors++;
            $display("FAIL rnd_grant_%0d got if=%b mem=%b want if=%b mem=%b (ifv=%b memv=%b)",
                     t, if_req_ready, mem_req_ready, !want_mem, want_mem, ifv, memv);
         end
         exp_q.push_back(want_mem ? {m_wen, m_addr, m_wd, m_st} : {1'b0, i_addr, 64'd0, 8'd0});
         model_idle_cycle(ifv, memv);
         tick();
         if_req_addr   = {$urandom, $urandom};
         mem_req_addr  = {$urandom, $urandom};
         mem_req_wdata = {$urandom, $urandom};
         exp_f = exp_q.pop_front();
         d = $urandom_range(0, 2);
         for (int c = 0; c <= d; c++) begin
            bus_req_ready  = (c == d);
            bus_resp_valid = 1'($urandom);
            settle();
            checks++;
            if ({bus_req_valid, if_resp_valid, mem_resp_valid, if_req_ready, mem_req_ready,
                 bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb} !== {5'b10000, exp_f}) begin
               errors++;
               $display("FAIL rnd_issue_%0d got v=%b addr=%h wd=%h st=%h wen=%b want addr=%h",
                        t, bus_req_valid, bus_req_addr, bus_req_wdata, bus_req_wstrb, bus_req_wen,
                        exp_f[FW-2 -: AW]);
            end
            tick();
         end
         bus_req_ready = 1'b0;
         d = $urandom_range(0, 2);
         for (int c = 0; c <= d; c++) begin
            rd = {$urandom, $urandom};
            bus_resp_valid = (c == d);
            bus_resp_data  = rd;
            settle();
            checks++;
            if (c < d) begin
               if ({if_resp_valid, mem_resp_valid} !== 2'b00) begin
                  errors++;
                  $display("FAIL rnd_wait_%0d got if=%b mem=%b want 00", t, if_resp_valid, mem_resp_valid);
               end
            end else if ({if_resp_valid, mem_resp_valid, if_resp_data, mem_resp_data} !==
                         {!want_mem, want_mem, want_mem ? 64'd0 : rd,
                          (want_mem && !exp_f[FW-1]) ? rd : 64'd0}) begin
               errors++;
               $display("FAIL rnd_resp_%0d got if=%b/%h mem=%b/%h want owner_mem=%b rd=%h",
                        t, if_resp_valid, if_resp_data, mem_resp_valid, mem_resp_data, want_mem, rd);
            end
            tick();
         end
         bus_resp_valid = 1'b0;
      end
      idle_inputs();
      model_idle_cycle(1'b0, 1'b0);
      tick();
   endtask

   task automatic test_perf;
      logic [31:0] want_if, want_mem;
      do_reset();
      for (int i = 0; i < 5; i++) simple_txn(1'b0, 64'(i * 8));
      for (int i = 0; i < 7; i++) simple_txn(1'b1, 64'(i * 16));
`ifdef MEM_PORT_ARB_PERF_EN
      want_if  = 32'd5;
      want_mem = 32'd7;
`else
      want_if  = 32'd0;
      want_mem = 32'd0;
`endif
      settle();
      checks++;
      if ({perf_if_cnt, perf_mem_cnt} !== {want_if, want_mem}) begin
         errors++;
         $display("FAIL perf_counts got if=%0d mem=%0d want if=%0d mem=%0d",
                  perf_if_cnt, perf_mem_cnt, want_if, want_mem);
      end
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog timeout reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_if_fetch();
      test_starvation();
      test_store_stall();
      test_spurious_resp();
      test_reset_in_wait();
      test_random();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
